// File: rtl/fwrdk2j_pipe.sv
// Radix-2 butterfly (sum/difference) as a 2-stage valid/ready pipeline with wrap, saturate and scale modes.
// Latency 2 cycles, 1 pair/cycle; a stalled sink freezes S2, then S1, then deasserts in_ready.
module fwrdk2j_pipe #(
    parameter int W     = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in0,
    input  logic [W-1:0]     in1,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out0,
    output logic [W-1:0]     out1,
    output logic             ovf0,
    output logic             ovf1,
    output logic             ovf_sticky,
    input  logic             clr,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        MODE_WRAP  = 2'd0,
        MODE_SAT   = 2'd1,
        MODE_SCALE = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [W-1:0] val;
        logic         ovf;
    } res_t;

    // Reduce a (W+1)-bit exact result to W bits according to the sample's mode.
    function automatic res_t shape(input logic [W:0] r, input mode_e m);
        res_t o;
        o.ovf = r[W] ^ r[W-1];
        o.val = r[W-1:0];
        case (m)
            MODE_SAT: begin
                if (o.ovf) begin
                    o.val = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                end
            end
            MODE_SCALE: begin
                o.val = r[W:1];
                o.ovf = 1'b0;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Stage 1 registers
    logic         s1_v_q, s1_v_d;
    logic [W-1:0] s1_a_q, s1_a_d;
    logic [W-1:0] s1_b_q, s1_b_d;
    mode_e        s1_m_q, s1_m_d;

    // Stage 2 registers
    logic         s2_v_q, s2_v_d;
    logic [W-1:0] s2_o0_q, s2_o0_d;
    logic [W-1:0] s2_o1_q, s2_o1_d;
    logic         s2_f0_q, s2_f0_d;
    logic         s2_f1_q, s2_f1_d;

    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       s1_load, s2_load, deliver;
    logic [W:0] sum_w, dif_w;
    res_t       sum_r, dif_r;

    assign s2_load  = !s2_v_q || out_ready;
    assign s1_load  = !s1_v_q || s2_load;
    assign in_ready = s1_load;
    assign deliver  = s2_v_q && out_ready;

    assign sum_w = {s1_a_q[W-1], s1_a_q} + {s1_b_q[W-1], s1_b_q};
    assign dif_w = {s1_a_q[W-1], s1_a_q} - {s1_b_q[W-1], s1_b_q};
    assign sum_r = shape(sum_w, s1_m_q);
    assign dif_r = shape(dif_w, s1_m_q);

    always_comb begin
        s1_v_d  = s1_v_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s1_m_d  = s1_m_q;
        s2_v_d  = s2_v_q;
        s2_o0_d = s2_o0_q;
        s2_o1_d = s2_o1_q;
        s2_f0_d = s2_f0_q;
        s2_f1_d = s2_f1_q;

        if (s1_load) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_a_d = in0;
                s1_b_d = in1;
                s1_m_d = mode_e'(mode);
            end
        end

        // Result registers only change when a real sample moves in, so a drained
        // output keeps showing the last delivered pair.
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_o0_d = sum_r.val;
                s2_o1_d = dif_r.val;
                s2_f0_d = sum_r.ovf;
                s2_f1_d = dif_r.ovf;
            end
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else if (deliver) begin
            sticky_d = sticky_q | s2_f0_q | s2_f1_q;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_m_q   <= MODE_WRAP;
            s2_v_q   <= 1'b0;
            s2_o0_q  <= '0;
            s2_o1_q  <= '0;
            s2_f0_q  <= 1'b0;
            s2_f1_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_m_q   <= s1_m_d;
            s2_v_q   <= s2_v_d;
            s2_o0_q  <= s2_o0_d;
            s2_o1_q  <= s2_o1_d;
            s2_f0_q  <= s2_f0_d;
            s2_f1_q  <= s2_f1_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign out0       = s2_o0_q;
    assign out1       = s2_o1_q;
    assign ovf0       = s2_f0_q;
    assign ovf1       = s2_f1_q;
    assign ovf_sticky = sticky_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_fwrdk2j_pipe.sv
// Scoreboard bench for fwrdk2j_pipe: directed butterfly/overflow/stall/reset cases, then a randomised stream.
module tb_fwrdk2j_pipe;
    localparam int W     = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in0 = '0;
    logic [W-1:0]     in1 = '0;
    logic [1:0]       mode = 2'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out0;
    logic [W-1:0]     out1;
    logic             ovf0;
    logic             ovf1;
    logic             ovf_sticky;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] sample_cnt;

    fwrdk2j_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in0        (in0),
        .in1        (in1),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out0       (out0),
        .out1       (out1),
        .ovf0       (ovf0),
        .ovf1       (ovf1),
        .ovf_sticky (ovf_sticky),
        .clr        (clr),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] o0;
        logic [31:0] o1;
        logic        v0;
        logic        v1;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_cnt = '0;
    logic        exp_sticky = 1'b0;
    bit          lat_chk = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference butterfly leg evaluated in 64-bit integer arithmetic.
    function automatic void golden(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                   input bit is_sub, output logic [31:0] r, output logic ovf);
        longint x;
        longint maxv;
        longint minv;
        maxv = 64'sd2147483647;
        minv = -64'sd2147483648;
        x = is_sub ? (longint'($signed(a)) - longint'($signed(b)))
                   : (longint'($signed(a)) + longint'($signed(b)));
        ovf = (x > maxv) || (x < minv);
        if (m == 2'd2) begin
            r   = 32'(x >>> 1);
            ovf = 1'b0;
        end else if (m == 2'd1 && ovf) begin
            r = (x > maxv) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else begin
            r = x[31:0];
        end
    endfunction

    // One clock: drive at negedge, evaluate handshakes just before the rising edge.
    task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input logic ordy, input logic c, output bit acc);
        exp_t e;
        exp_t p;
        bit   dlv;
        bit   popped;
        in_valid  = iv;
        in0       = a;
        in1       = b;
        mode      = m;
        out_ready = ordy;
        clr       = c;
        #1;
        check_eq("cnt", 64'(sample_cnt), 64'(exp_cnt));
        check_eq("sticky", 64'(ovf_sticky), 64'(exp_sticky));
        acc    = iv && in_ready;
        dlv    = out_valid && ordy;
        popped = 1'b0;
        if (dlv) begin
            if (sbq.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                p = sbq.pop_front();
                popped = 1'b1;
                check_eq("out0", 64'(out0), 64'(p.o0));
                check_eq("out1", 64'(out1), 64'(p.o1));
                check_eq("ovf0", 64'(ovf0), 64'(p.v0));
                check_eq("ovf1", 64'(ovf1), 64'(p.v1));
                if (lat_chk) check_eq("latency", 64'(cyc - p.acc), 64'd2);
            end
        end
        if (c) begin
            exp_cnt    = '0;
            exp_sticky = 1'b0;
        end else if (dlv) begin
            exp_cnt = exp_cnt + 1;
            if (popped && (p.v0 || p.v1)) exp_sticky = 1'b1;
        end
        if (acc) begin
            golden(a, b, m, 1'b0, e.o0, e.v0);
            golden(a, b, m, 1'b1, e.o1, e.v1);
            e.acc = cyc;
            sbq.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            cycle(1'b1, a, b, m, 1'b1, 1'b0, acc);
            n++;
        end
        if (!acc) check_eq("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain(input int budget);
        bit acc;
        int n;
        n = 0;
        while (sbq.size() > 0 && n < budget) begin
            cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0, acc);
            n++;
        end
        check_eq("drain", 64'(sbq.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        exp_cnt    = '0;
        exp_sticky = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out0", 64'(out0), 64'd0);
        check_eq("rst_out1", 64'(out1), 64'd0);
        check_eq("rst_ovf", 64'({ovf0, ovf1}), 64'd0);
        check_eq("rst_sticky", 64'(ovf_sticky), 64'd0);
        check_eq("rst_cnt", 64'(sample_cnt), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        cyc++;
    endtask

    logic [31:0] sa [6];
    logic [31:0] sb [6];

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'($urandom_range(0, 15)) - 32'd8;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          acc;
        int          k;
        int          sent;
        logic [31:0] h0;
        logic [31:0] h1;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rm;
        logic        rv;

        @(negedge clk);
        do_reset();

        // Basic stream with latency check
        lat_chk = 1'b1;
        send(32'd5, 32'd3, 2'd0);
        send(-32'sd7, 32'd2, 2'd0);
        send(32'd0, 32'd0, 2'd0);
        drain(20);
        lat_chk = 1'b0;
        check_eq("cnt_after_3", 64'(sample_cnt), 64'd3);

        // Wrap overflow sets sticky
        send(32'h7FFF_FFFF, 32'd1, 2'd0);
        drain(20);
        check_eq("sticky_set", 64'(ovf_sticky), 64'd1);

        // Saturate, scale and reserved modes
        send(32'h7FFF_FFFF, 32'd1, 2'd1);
        send(32'h8000_0000, 32'd1, 2'd1);
        send(32'h7FFF_FFFF, 32'd1, 2'd2);
        send(-32'sd3, 32'd0, 2'd2);
        send(32'h8000_0000, 32'h7FFF_FFFF, 2'd2);
        send(32'h8000_0000, 32'h8000_0000, 2'd3);
        drain(30);

        // Stall: two accepts fill the pipe, outputs hold, nothing lost on release
        for (int i = 0; i < 6; i++) begin
            sa[i] = 32'd100 + 32'(i);
            sb[i] = 32'd7 * 32'(i);
        end
        k = 0;
        for (int s = 0; s < 5; s++) begin
            cycle(1'b1, sa[k], sb[k], 2'd0, 1'b0, 1'b0, acc);
            if (acc) k++;
            if (s == 1) begin
                h0 = out0;
                h1 = out1;
            end else if (s > 1) begin
                check_eq("stall_vld", 64'(out_valid), 64'd1);
                check_eq("stall_out0", 64'(out0), 64'(h0));
                check_eq("stall_out1", 64'(out1), 64'(h1));
                check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            end
        end
        check_eq("stall_accepts", 64'(k), 64'd2);
        while (k < 6) begin
            cycle(1'b1, sa[k], sb[k], 2'd0, 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        drain(20);
        check_eq("stall_cnt", 64'(sample_cnt), 64'(exp_cnt));

        // Clear coincident with an overflowing delivery
        send(32'h7FFF_FFFF, 32'd1, 2'd0);
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0, acc);
        check_eq("clr_pre_vld", 64'(out_valid), 64'd1);
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b1, acc);
        check_eq("clr_cnt", 64'(sample_cnt), 64'd0);
        check_eq("clr_sticky", 64'(ovf_sticky), 64'd0);

        // Reset with two samples in flight
        cycle(1'b1, 32'd11, 32'd22, 2'd0, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'd33, 32'd44, 2'd0, 1'b0, 1'b0, acc);
        check_eq("pre_rst_vld", 64'(out_valid), 64'd1);
        do_reset();
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0, acc);
        check_eq("post_rst_vld", 64'(out_valid), 64'd0);

        // Randomised stream with random backpressure, held offers and occasional clr
        sent = 0;
        ra = pick_operand();
        rb = pick_operand();
        rm = 2'($urandom_range(0, 3));
        while (sent < 20000 && cyc < 60000) begin
            rv = ($urandom_range(0, 3) != 0);
            cycle(rv, ra, rb, rm, ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0), acc);
            if (acc) begin
                sent++;
                ra = pick_operand();
                rb = pick_operand();
                rm = 2'($urandom_range(0, 3));
            end
        end
        check_eq("rand_sent", 64'(sent), 64'd20000);
        drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
